// File: rtl/multu_sequencer.sv
// Control sequencer for an iterative unsigned multiply: broadcasts the ALU op code,
// drives multiplier load/step strobes, and writes Hi/Lo after WIDTH shift-add steps.
module multu_sequencer #(
  parameter int         WIDTH       = 32,
  parameter logic [5:0] FUNCT_MULTU = 6'd25,
  parameter logic [5:0] HILO_OPEN   = 6'b111111
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [5:0]               funct,
  output logic [5:0]               op_out,
  output logic                     mul_load,
  output logic                     mul_step,
  output logic                     hilo_we,
  output logic [$clog2(WIDTH):0]   mul_count,
  output logic                     busy,
  output logic                     done,
  output logic                     stall
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t        r_state;
  logic [5:0]    r_op;
  logic [CW-1:0] r_count;

  logic w_is_multu;
  logic w_idle;

  assign w_is_multu = (funct == FUNCT_MULTU);
  assign w_idle     = (r_state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 6'd0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (valid) begin
            if (w_is_multu) begin
              r_state <= S_LOAD;
              r_op    <= FUNCT_MULTU;
            end else begin
              r_op    <= funct;
            end
          end
        end
        S_LOAD: begin
          r_count <= '0;
          r_op    <= FUNCT_MULTU;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Count saturates at WIDTH on the final step; WRITE clears it.
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_state <= S_WRITE;
            r_op    <= HILO_OPEN;
          end else begin
            r_op    <= FUNCT_MULTU;
          end
        end
        S_WRITE: begin
          r_count <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_count <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are pure state decodes, so they are one-hot by construction.
  assign mul_load  = (r_state == S_LOAD);
  assign mul_step  = (r_state == S_RUN);
  assign hilo_we   = (r_state == S_WRITE);
  assign done      = (r_state == S_WRITE);
  assign busy      = !w_idle;
  assign stall     = busy | (valid & w_is_multu & w_idle);
  assign op_out    = r_op;
  assign mul_count = r_count;

endmodule

// File: tb/tb_multu_sequencer.sv
// Directed bench for multu_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [5:0] funct;
  logic [5:0] op_out;
  logic       mul_load, mul_step, hilo_we, busy, done, stall;
  logic [5:0] mul_count;

  multu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .funct     (funct),
    .op_out    (op_out),
    .mul_load  (mul_load),
    .mul_step  (mul_step),
    .hilo_we   (hilo_we),
    .mul_count (mul_count),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  // flags = {mul_load, mul_step, hilo_we, done, busy, stall}
  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_STALL = 6'b000001;
  localparam logic [5:0] F_LOAD  = 6'b100011;
  localparam logic [5:0] F_RUN   = 6'b010011;
  localparam logic [5:0] F_WRITE = 6'b001111;

  typedef struct {
    string      name;
    logic [5:0] op;
    bit         chk_op;
    logic [5:0] flags;
    logic [5:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [5:0] act_flags;
      logic [5:0] act_op;
      e = q.pop_front();
      act_flags = {mul_load, mul_step, hilo_we, done, busy, stall};
      act_op    = e.chk_op ? op_out : e.op;
      checks++;
      if (act_flags !== e.flags || mul_count !== e.cnt || act_op !== e.op) begin
        errors++;
        $display("FAIL %s: got op=%0d flags=%b cnt=%0d, expected op=%0d flags=%b cnt=%0d",
                 e.name, op_out, act_flags, mul_count, e.op, e.flags, e.cnt);
      end
    end
  end

  task automatic push(input string nm, input logic [5:0] eop, input bit chk,
                      input logic [5:0] flags, input logic [5:0] ecnt);
    exp_t e;
    e.name = nm; e.op = eop; e.chk_op = chk; e.flags = flags; e.cnt = ecnt;
    q.push_back(e);
  endtask

  // Drive inputs for the next cycle and record what the DUT must show in it.
  task automatic step(input bit v, input logic [5:0] f, input bit r, input string nm,
                      input logic [5:0] eop, input bit chk, input logic [5:0] flags,
                      input logic [5:0] ecnt);
    @(posedge clk);
    #1;
    valid = v; funct = f; rst = r;
    push(nm, eop, chk, flags, ecnt);
  endtask

  // Cycles 1..WIDTH+2 after the accept edge, with inputs held at v/f throughout.
  task automatic run_seq(input bit v, input logic [5:0] f, input string tag);
    step(v, f, 1'b0, {tag, "_load"}, 6'd25, 1'b1, F_LOAD, 6'd0);
    for (int k = 0; k < 32; k++)
      step(v, f, 1'b0, {tag, "_run"}, 6'd25, 1'b1, F_RUN, 6'(k));
    step(v, f, 1'b0, {tag, "_write"}, 6'd63, 1'b1, F_WRITE, 6'd32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; funct = 6'd0;

    // Reset state, then a plain ADD broadcast with one-edge latency.
    step(1'b0, 6'd0,  1'b1, "rst_state",  6'd0,  1'b1, F_NONE,  6'd0);
    step(1'b1, 6'd32, 1'b0, "add_req",    6'd0,  1'b1, F_NONE,  6'd0);
    step(1'b0, 6'd0,  1'b0, "add_result", 6'd32, 1'b1, F_NONE,  6'd0);

    // Single MULTU: stall rises combinationally in the request cycle.
    step(1'b1, 6'd25, 1'b0, "mul_req",    6'd32, 1'b1, F_STALL, 6'd0);
    run_seq(1'b0, 6'd0, "mul");
    step(1'b0, 6'd0,  1'b0, "mul_after",  6'd0,  1'b0, F_NONE,  6'd0);

    // MULTU then AND held during the whole multiply.
    step(1'b1, 6'd25, 1'b0, "and_req",    6'd0,  1'b0, F_STALL, 6'd0);
    run_seq(1'b1, 6'd36, "and");
    step(1'b1, 6'd36, 1'b0, "and_idle",   6'd0,  1'b0, F_NONE,  6'd0);
    step(1'b0, 6'd0,  1'b0, "and_result", 6'd36, 1'b1, F_NONE,  6'd0);

    // Back-to-back MULTU: re-accept only at the first IDLE edge after WRITE.
    step(1'b1, 6'd25, 1'b0, "b2b_req",    6'd36, 1'b1, F_STALL, 6'd0);
    run_seq(1'b1, 6'd25, "b2b1");
    step(1'b1, 6'd25, 1'b0, "b2b_idle",   6'd0,  1'b0, F_STALL, 6'd0);
    run_seq(1'b0, 6'd0, "b2b2");
    step(1'b0, 6'd0,  1'b0, "b2b_after",  6'd0,  1'b0, F_NONE,  6'd0);

    // Asynchronous reset mid-RUN at mul_count=17.
    step(1'b1, 6'd25, 1'b0, "ar_req",     6'd0,  1'b0, F_STALL, 6'd0);
    step(1'b0, 6'd0,  1'b0, "ar_load",    6'd25, 1'b1, F_LOAD,  6'd0);
    for (int k = 0; k < 17; k++)
      step(1'b0, 6'd0, 1'b0, "ar_run", 6'd25, 1'b1, F_RUN, 6'(k));
    @(posedge clk);
    #1;
    valid = 1'b0;
    push("ar_async_clear", 6'd0, 1'b1, F_NONE, 6'd0);
    #2 rst = 1'b1;
    step(1'b0, 6'd0, 1'b1, "ar_hold",    6'd0, 1'b1, F_NONE, 6'd0);
    step(1'b0, 6'd0, 1'b0, "ar_release", 6'd0, 1'b1, F_NONE, 6'd0);
    for (int k = 0; k < 20; k++)
      step(1'b0, 6'd0, 1'b0, "ar_no_hilo", 6'd0, 1'b1, F_NONE, 6'd0);
    step(1'b1, 6'd25, 1'b0, "ar_new_req", 6'd0, 1'b1, F_STALL, 6'd0);
    run_seq(1'b0, 6'd0, "ar_new");
    step(1'b0, 6'd0,  1'b0, "ar_after",   6'd0, 1'b0, F_NONE, 6'd0);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
